clause_flag_collector: RTL and testbench

- Sequential producer feeding the unsatisfied-clause-at-random compare tree (stochastic search).
- Collects per-clause satisfied/unsatisfied results streamed from the clause evaluator into a flag vector.
- Counts the unsatisfied clauses and supplies the random per-node choice bits from an internal LFSR.
- Presents a stable flag vector and setting vector to the compare tree until the consumer acknowledges.

---
 rtl/clause_flag_collector.sv | 105 ++++++++++
 tb/tb_clause_flag_collector.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clause_flag_collector.sv
// Collects streamed clause results into a flag vector and supplies
// random compare-node choice bits for the unsatisfied-clause tree.
module clause_flag_collector #(
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic in_clk,
  input  logic in_reset_n,
  input  logic in_start,
  input  logic in_result_valid,
  input  logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] in_result_index,
  input  logic in_result_satisfied,
  output logic out_result_ready,
  input  logic in_ack,
  output logic [(1<<MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX)-1:0] out_clause_satisfied,
  output logic [(1<<MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX)-2:0] out_settings,
  output logic out_flags_valid,
  output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX:0] out_unsat_count,
  output logic out_all_satisfied,
  output logic out_error
);

  localparam int W = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX;
  localparam int N = 1 << W;
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_READY
  } state_t;

  state_t state, state_n;

  logic [N-1:0] received;
  logic [15:0]  lfsr;
  logic         accept;
  logic         dup;
  logic         full;

  assign accept = in_result_valid & (state == S_COLLECT) & ~in_start;
  assign dup    = received[in_result_index];
  assign full   = &received;

  always_comb begin
    state_n = state;
    if (in_start) begin
      state_n = S_COLLECT;
    end else begin
      unique case (state)
        S_IDLE:    state_n = S_IDLE;
        S_COLLECT: if (full) state_n = S_READY;
        S_READY:   if (in_ack) state_n = S_IDLE;
        default:   state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      out_clause_satisfied <= '1;
      received             <= '0;
      out_unsat_count      <= '0;
      out_error            <= 1'b0;
    end else if (in_start) begin
      out_clause_satisfied <= '1;
      received             <= '0;
      out_unsat_count      <= '0;
      out_error            <= 1'b0;
    end else if (accept) begin
      if (dup) begin
        out_error <= 1'b1;
      end else begin
        out_clause_satisfied[in_result_index] <= in_result_satisfied;
        received[in_result_index]             <= 1'b1;
        if (!in_result_satisfied) begin
          out_unsat_count <= out_unsat_count + (W+1)'(1);
        end
      end
    end
  end

  // Galois x^16+x^14+x^13+x^11+1; frozen while the tree holds its selection
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      lfsr <= SEED;
    end else if (state != S_READY) begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign out_result_ready  = (state == S_COLLECT);
  assign out_flags_valid   = (state == S_READY);
  assign out_all_satisfied = out_flags_valid & (out_unsat_count == '0);
  assign out_settings      = lfsr[N-2:0];

endmodule

// File: tb/tb_clause_flag_collector.sv
// Directed bench for clause_flag_collector, W=3 (8 clauses),
// with a bench-side LFSR model for out_settings.
module tb_clause_flag_collector;

  logic       in_clk = 1'b0;
  logic       in_reset_n;
  logic       in_start;
  logic       in_result_valid;
  logic [2:0] in_result_index;
  logic       in_result_satisfied;
  logic       out_result_ready;
  logic       in_ack;
  logic [7:0] out_clause_satisfied;
  logic [6:0] out_settings;
  logic       out_flags_valid;
  logic [3:0] out_unsat_count;
  logic       out_all_satisfied;
  logic       out_error;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] m_lfsr;
  logic        m_run;
  logic [6:0]  held;

  clause_flag_collector #(
    .MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX(3),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .in_clk(in_clk),
    .in_reset_n(in_reset_n),
    .in_start(in_start),
    .in_result_valid(in_result_valid),
    .in_result_index(in_result_index),
    .in_result_satisfied(in_result_satisfied),
    .out_result_ready(out_result_ready),
    .in_ack(in_ack),
    .out_clause_satisfied(out_clause_satisfied),
    .out_settings(out_settings),
    .out_flags_valid(out_flags_valid),
    .out_unsat_count(out_unsat_count),
    .out_all_satisfied(out_all_satisfied),
    .out_error(out_error)
  );

  always #5 in_clk = ~in_clk;

  function automatic logic [15:0] lstep(input logic [15:0] x);
    logic [15:0] y;
    y = {1'b0, x[15:1]};
    if (x[0]) y = y ^ 16'hB400;
    return y;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // m_run mirrors "DUT not in READY before this edge"
  task automatic tick();
    @(posedge in_clk);
    if (m_run) m_lfsr = lstep(m_lfsr);
    #1;
  endtask

  task automatic send(input logic [2:0] idx, input logic sat);
    in_result_valid     = 1'b1;
    in_result_index     = idx;
    in_result_satisfied = sat;
    tick();
    in_result_valid     = 1'b0;
  endtask

  task automatic start_round();
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
  endtask

  initial begin
    in_reset_n          = 1'b0;
    in_start            = 1'b0;
    in_result_valid     = 1'b0;
    in_result_index     = 3'd0;
    in_result_satisfied = 1'b0;
    in_ack              = 1'b0;
    m_lfsr              = 16'hACE1;
    m_run               = 1'b1;
    #12;
    chk("rst_flags", 32'(out_clause_satisfied), 32'hFF);
    chk("rst_count", 32'(out_unsat_count), 32'd0);
    chk("rst_valid", 32'(out_flags_valid), 32'd0);
    chk("rst_ready", 32'(out_result_ready), 32'd0);
    chk("rst_error", 32'(out_error), 32'd0);
    chk("rst_settings", 32'(out_settings), 32'h61);
    in_reset_n = 1'b1;
    tick();
    chk("idle_step", 32'(out_settings), 32'(m_lfsr[6:0]));

    // mixed burst 0..7, satisfied = 1,0,1,1,0,1,1,1
    start_round();
    chk("mix_ready", 32'(out_result_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      send(3'(i), !(i == 1 || i == 4));
    end
    chk("mix_valid_early", 32'(out_flags_valid), 32'd0);
    tick();
    m_run = 1'b0;
    chk("mix_valid", 32'(out_flags_valid), 32'd1);
    chk("mix_flags", 32'(out_clause_satisfied), 32'hED);
    chk("mix_count", 32'(out_unsat_count), 32'd2);
    chk("mix_allsat", 32'(out_all_satisfied), 32'd0);
    chk("mix_rdy_low", 32'(out_result_ready), 32'd0);
    chk("frz_entry", 32'(out_settings), 32'(m_lfsr[6:0]));
    held = out_settings;

    // hold READY 20 cycles with junk results offered
    for (int i = 0; i < 20; i++) begin
      in_result_valid     = 1'b1;
      in_result_index     = 3'(i);
      in_result_satisfied = 1'b0;
      tick();
    end
    in_result_valid = 1'b0;
    chk("frz_settings", 32'(out_settings), 32'(held));
    chk("frz_flags", 32'(out_clause_satisfied), 32'hED);
    chk("frz_count", 32'(out_unsat_count), 32'd2);
    in_ack = 1'b1;
    tick();
    in_ack = 1'b0;
    m_run  = 1'b1;
    chk("ack_valid", 32'(out_flags_valid), 32'd0);
    chk("ack_flags_kept", 32'(out_clause_satisfied), 32'hED);
    chk("ack_settings", 32'(out_settings), 32'(held));
    tick();
    chk("resume1", 32'(out_settings), 32'(m_lfsr[6:0]));
    tick();
    chk("resume2", 32'(out_settings), 32'(m_lfsr[6:0]));

    // idle ignores results
    send(3'd3, 1'b0);
    chk("idle_ignore_cnt", 32'(out_unsat_count), 32'd2);
    chk("idle_ignore_flg", 32'(out_clause_satisfied), 32'hED);

    // all satisfied, out of order with gaps
    start_round();
    send(3'd7, 1'b1); tick();
    send(3'd3, 1'b1); tick();
    send(3'd0, 1'b1); tick();
    send(3'd5, 1'b1); tick(); tick();
    send(3'd1, 1'b1); tick();
    send(3'd6, 1'b1);
    send(3'd2, 1'b1); tick();
    send(3'd4, 1'b1);
    tick();
    m_run = 1'b0;
    chk("all_valid", 32'(out_flags_valid), 32'd1);
    chk("all_allsat", 32'(out_all_satisfied), 32'd1);
    chk("all_count", 32'(out_unsat_count), 32'd0);
    chk("all_error", 32'(out_error), 32'd0);
    in_ack = 1'b1;
    tick();
    in_ack = 1'b0;
    m_run  = 1'b1;
    chk("all_ack_allsat", 32'(out_all_satisfied), 32'd0);

    // duplicate index 2
    start_round();
    send(3'd2, 1'b0);
    send(3'd2, 1'b1);
    chk("dup_error", 32'(out_error), 32'd1);
    chk("dup_flags", 32'(out_clause_satisfied), 32'hFB);
    chk("dup_count", 32'(out_unsat_count), 32'd1);
    chk("dup_ready", 32'(out_result_ready), 32'd1);
    send(3'd0, 1'b1);
    send(3'd1, 1'b1);
    send(3'd3, 1'b1);
    send(3'd4, 1'b1);
    send(3'd5, 1'b1);
    send(3'd6, 1'b1);
    chk("dup_still_coll", 32'(out_result_ready), 32'd1);
    send(3'd7, 1'b1);
    tick();
    m_run = 1'b0;
    chk("dup_valid", 32'(out_flags_valid), 32'd1);
    chk("dup_final_flags", 32'(out_clause_satisfied), 32'hFB);
    chk("dup_final_count", 32'(out_unsat_count), 32'd1);
    chk("dup_final_err", 32'(out_error), 32'd1);
    in_ack = 1'b1;
    tick();
    in_ack = 1'b0;
    m_run  = 1'b1;

    // restart mid-collect
    start_round();
    for (int i = 0; i < 4; i++) send(3'(i), 1'b0);
    chk("rs_count_pre", 32'(out_unsat_count), 32'd4);
    start_round();
    chk("rs_flags", 32'(out_clause_satisfied), 32'hFF);
    chk("rs_count", 32'(out_unsat_count), 32'd0);
    chk("rs_ready", 32'(out_result_ready), 32'd1);
    for (int i = 0; i < 8; i++) send(3'(i), i != 5);
    tick();
    m_run = 1'b0;
    chk("rs_valid", 32'(out_flags_valid), 32'd1);
    chk("rs_flags_full", 32'(out_clause_satisfied), 32'hDF);
    in_start = 1'b1;
    in_ack   = 1'b1;
    tick();
    in_start = 1'b0;
    in_ack   = 1'b0;
    m_run    = 1'b1;
    chk("sa_valid", 32'(out_flags_valid), 32'd0);
    chk("sa_ready", 32'(out_result_ready), 32'd1);
    chk("sa_flags", 32'(out_clause_satisfied), 32'hFF);
    chk("sa_count", 32'(out_unsat_count), 32'd0);
    chk("sa_settings", 32'(out_settings), 32'(m_lfsr[6:0]));
    send(3'd0, 1'b0);
    send(3'd0, 1'b1);
    chk("sa_count1", 32'(out_unsat_count), 32'd1);
    chk("sa_err", 32'(out_error), 32'd1);

    // asynchronous reset mid-collect, no clock edge
    in_reset_n = 1'b0;
    m_lfsr     = 16'hACE1;
    #1;
    chk("ar_flags", 32'(out_clause_satisfied), 32'hFF);
    chk("ar_count", 32'(out_unsat_count), 32'd0);
    chk("ar_error", 32'(out_error), 32'd0);
    chk("ar_ready", 32'(out_result_ready), 32'd0);
    chk("ar_settings", 32'(out_settings), 32'h61);
    in_reset_n = 1'b1;
    tick();
    chk("ar_idle", 32'(out_result_ready), 32'd0);
    chk("ar_step", 32'(out_settings), 32'(m_lfsr[6:0]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
